// File: rtl/dm_write_buffer_if.sv
// Store/load/DM-write bundle for the data-memory write buffer.
// The slave side is the buffer. The master side is the MEM stage together with the DM write port.
interface dm_write_buffer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              st_valid;
  logic [31:0]       st_pc;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_fwd_hit;
  logic [DATA_W-1:0] ld_fwd_data;

  logic              stall;

  logic              dm_ready;
  logic              dm_we;
  logic [31:0]       dm_pc;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;

  logic              buf_empty;

  modport slave (
    input  st_valid, st_pc, st_addr, st_data, ld_valid, ld_addr, dm_ready,
    output st_ready, ld_fwd_hit, ld_fwd_data, stall, dm_we, dm_pc, dm_addr,
           dm_wdata, buf_empty
  );

  modport master (
    output st_valid, st_pc, st_addr, st_data, ld_valid, ld_addr, dm_ready,
    input  st_ready, ld_fwd_hit, ld_fwd_data, stall, dm_we, dm_pc, dm_addr,
           dm_wdata, buf_empty
  );
endinterface

// File: rtl/dm_write_buffer.sv
// In-order store buffer in front of the DM write port. When WBUF_FWD_EN is defined, it forwards
// load data from pending stores. Otherwise it stalls any load that matches a pending store.
module dm_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  dm_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       pc_mem   [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic push;
  logic pop;
  logic ld_match;
  logic ld_stall;
  logic [PTR_W-1:0] idx;
`ifdef WBUF_FWD_EN
  logic [DATA_W-1:0] match_data;
`endif

  assign full = (count == CNT_W'(DEPTH));
  assign push = bus.st_valid & ~full;
  assign pop  = (count != '0) & bus.dm_ready;

  assign bus.st_ready  = ~full;
  assign bus.dm_we     = pop;
  assign bus.dm_pc     = pc_mem[rd_ptr];
  assign bus.dm_addr   = addr_mem[rd_ptr];
  assign bus.dm_wdata  = data_mem[rd_ptr];
  assign bus.buf_empty = (count == '0);

  // The scan runs from oldest to youngest, so a later match overwrites an earlier one and the youngest wins.
  always_comb begin
    ld_match = 1'b0;
    idx      = '0;
`ifdef WBUF_FWD_EN
    match_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_mem[idx] == bus.ld_addr)) begin
        ld_match = 1'b1;
`ifdef WBUF_FWD_EN
        match_data = data_mem[idx];
`endif
      end
    end
  end

`ifdef WBUF_FWD_EN
  assign bus.ld_fwd_hit  = bus.ld_valid & ld_match;
  assign bus.ld_fwd_data = (bus.ld_valid & ld_match) ? match_data : '0;
  assign ld_stall        = 1'b0;
`else
  assign bus.ld_fwd_hit  = 1'b0;
  assign bus.ld_fwd_data = '0;
  assign ld_stall        = bus.ld_valid & ld_match;
`endif

  assign bus.stall = (bus.st_valid & full) | ld_stall;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= bus.st_pc;
      addr_mem[wr_ptr] <= bus.st_addr;
      data_mem[wr_ptr] <= bus.st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop)
        count <= count + CNT_W'(1);
      else if (~push & pop)
        count <= count - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dm_write_buffer.sv
// Bench for dm_write_buffer: directed scenarios plus random traffic, checked against a queue model.
module tb_dm_write_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dm_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]       pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } st_t;

  st_t q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Entered at posedge+1. Drives one cycle of inputs and checks at the negedge.
  // The model is then updated for the coming edge.
  task automatic step(input logic sv, input logic [31:0] pc, input logic [ADDR_W-1:0] sa,
                      input logic [DATA_W-1:0] sd, input logic lv,
                      input logic [ADDR_W-1:0] la, input logic dr);
    logic              e_ready, e_we, m, e_hit, e_lst, e_stall;
    logic [DATA_W-1:0] md, e_fd;
    st_t               s;
    bus.st_valid = sv; bus.st_pc = pc; bus.st_addr = sa; bus.st_data = sd;
    bus.ld_valid = lv; bus.ld_addr = la; bus.dm_ready = dr;
    #4;
    e_ready = (q.size() != DEPTH);
    e_we    = (q.size() != 0) && dr;
    m  = 1'b0;
    md = '0;
    foreach (q[i]) if (q[i].addr == la) begin m = 1'b1; md = q[i].data; end
`ifdef WBUF_FWD_EN
    e_hit = lv && m;
    e_fd  = e_hit ? md : '0;
    e_lst = 1'b0;
`else
    e_hit = 1'b0;
    e_fd  = '0;
    e_lst = lv && m;
`endif
    e_stall = (sv && !e_ready) || e_lst;
    chk("st_ready", 64'(bus.st_ready), 64'(e_ready));
    chk("dm_we", 64'(bus.dm_we), 64'(e_we));
    chk("buf_empty", 64'(bus.buf_empty), 64'(q.size() == 0));
    chk("stall", 64'(bus.stall), 64'(e_stall));
    chk("ld_fwd_hit", 64'(bus.ld_fwd_hit), 64'(e_hit));
    chk("ld_fwd_data", 64'(bus.ld_fwd_data), 64'(e_fd));
    if (e_we) begin
      chk("dm_pc", 64'(bus.dm_pc), 64'(q[0].pc));
      chk("dm_addr", 64'(bus.dm_addr), 64'(q[0].addr));
      chk("dm_wdata", 64'(bus.dm_wdata), 64'(q[0].data));
      void'(q.pop_front());
    end
    if (sv && e_ready) begin
      s.pc = pc; s.addr = sa; s.data = sd;
      q.push_back(s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dr);
    step(1'b0, '0, '0, '0, 1'b0, '0, dr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.st_valid = 1'b0; bus.ld_valid = 1'b0; bus.dm_ready = 1'b1;
    bus.st_pc = '0; bus.st_addr = '0; bus.st_data = '0; bus.ld_addr = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    int guard;
    logic [ADDR_W-1:0] a;
    int op;
    do_reset();
    idle(1'b1);

    // 1: single store, drained the next cycle
    step(1'b1, 32'h3000, 12'h004, 32'h1234_5678, 1'b0, '0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // 2: fill with DM held off, then stall on 5th store, then drain
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h100 + 32'(i * 4), ADDR_W'(i), 32'hA000 + 32'(i), 1'b0, '0, 1'b0);
    step(1'b1, 32'h110, 12'h004, 32'hA004, 1'b0, '0, 1'b0);
    guard = 0;
    while (q.size() == DEPTH && guard < 8) begin
      step(1'b1, 32'h110, 12'h004, 32'hA004, 1'b0, '0, 1'b1);
      guard++;
    end
    chk("fifth_accept_bound", 64'(guard < 8), 64'd1);
    repeat (6) idle(1'b1);

    // 3: wrap with toggling dm_ready
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h200 + 32'(i * 4), ADDR_W'(i + 8), 32'hB000 + 32'(i), 1'b0, '0, 1'(i % 2));
    repeat (12) idle(1'b1);

    // 4/5: two stores to the same address, then load hits/misses
    step(1'b1, 32'h300, 12'h010, 32'hAAAA_AAAA, 1'b0, '0, 1'b0);
    step(1'b1, 32'h304, 12'h010, 32'hBBBB_BBBB, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 12'h010, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 12'h014, 1'b0);
    repeat (4) step(1'b0, '0, '0, '0, 1'b1, 12'h010, 1'b1);

    // 6: reset with three pending entries discards them
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h400 + 32'(i * 4), ADDR_W'(i + 32), 32'hC000 + 32'(i), 1'b0, '0, 1'b0);
    do_reset();
    repeat (4) idle(1'b1);

    // random traffic over a small address range to force load matches
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        op = int'($urandom_range(0, 9));
        a  = ADDR_W'($urandom_range(0, 7));
        if (op < 4)
          step(1'b1, $urandom, a, $urandom, 1'b0, '0, 1'($urandom_range(0, 9) < 6));
        else if (op < 7)
          step(1'b0, '0, '0, '0, 1'b1, a, 1'($urandom_range(0, 9) < 6));
        else
          idle(1'($urandom_range(0, 9) < 6));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
